bcd_counter: RTL and testbench
==============================

BCD_COUNTER -- requirements
Module: bcd_counter

Interface
REQ-001 Parameter: none; the digit range 0..9 is fixed.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Clear  input  1  reset, synchronous, active-high; sampled only on rising CLK.
REQ-004 count  output  4  current BCD digit, registered, range 0..9.
REQ-005 carry  output  1  registered ripple-carry pulse; usable directly as CLK of the next (higher) digit.
REQ-006 Positional port order SHALL be CLK, count, Clear, carry, for order-based instantiation in cascades.

Function
REQ-007 Clear=1 at rising CLK: count<=0, carry<=0; Clear has priority over counting.
REQ-008 Clear=0 at rising CLK, count in 0..8: count<=count+1, carry<=0.
REQ-009 Clear=0 at rising CLK, count=9: count<=0, carry<=1 (wrap 9->0).
REQ-010 carry SHALL be high for exactly one CLK period per wrap: it rises on the wrap edge and falls on the next edge (or on Clear).
REQ-011 The rising edge of carry SHALL coincide (same clock edge, register delay only) with count becoming 0, so a downstream digit increments once per upstream wrap.
REQ-012 Illegal count 10..15 (unreachable in normal use): the next non-Clear edge SHALL load 0 with carry<=0.
REQ-013 Latency: count and carry change only on rising CLK; no combinational path from any input to any output.
REQ-014 Clear asserted mid-count SHALL take effect on the next edge regardless of count value; if a carry pulse is high at that edge, it SHALL be dropped to 0.
REQ-015 Clear held for N edges keeps count=0, carry=0 for those edges; counting resumes on the first edge with Clear=0 (0->1).
REQ-016 In a ripple cascade, a stage clocked by carry sees Clear only on its own clock edges; the higher stage is therefore cleared only when its clock toggles, and cascade users SHALL guarantee that.

Reset
REQ-017 Reset is synchronous active-high via Clear only; no asynchronous reset, no reliance on power-up initial values.
REQ-018 Reset values: count=4'd0, carry=1'b0.

Structure
REQ-019 A shared package SHALL hold the constants BCD_MAX=4'd9 and BCD_ZERO=4'd0 and the 4-bit digit type, reused by the counter and its testbenches.
REQ-020 One always-block state register (count, carry) with next-state logic; no sub-module is needed, the block is itself the reusable single-digit cell.

Verification
REQ-021 Clear=1 for 2 edges from unknown state -> count=0, carry=0 after the first edge.
REQ-022 Release Clear, apply 9 edges -> count=9, carry=0; 10th edge -> count=0, carry=1; 11th edge -> count=1, carry=0.
REQ-023 Free-run 30 edges after clear -> exactly 3 carry pulses, each 1 CLK wide, aligned to count=0.
REQ-024 Assert Clear at count=5 -> next edge count=0; assert Clear on the wrap-pulse cycle -> carry=0 next edge.
REQ-025 Cascade two digits (units.carry -> tens.CLK), both cleared: after 10 edges tens=1, units=0; after 99 edges 9,9; edge 100 -> 0,0 with tens carry pulse=1.
REQ-026 Force count=12 (backdoor), Clear=0 -> next edge count=0, carry=0.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared definitions for the single-digit BCD counter cell and its benches.
//   digit_t  : one BCD digit (4 bits, legal range 0..9)
//   BCD_MAX  : last legal digit; the counter wraps to BCD_ZERO after it
//   BCD_ZERO : digit value after Clear and after a wrap
package bcd_counter_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t BCD_MAX  = 4'd9;
  localparam digit_t BCD_ZERO = 4'd0;

endpackage

// File: rtl/bcd_counter_if.sv
// Signal bundle for one BCD digit as seen by whoever drives and observes it.
//   Clear : synchronous active-high clear into the digit
//   count : current BCD digit out of the digit
//   carry : one-cycle wrap pulse out of the digit
// master : the controlling side (drives Clear, observes count/carry)
// slave  : the digit side (takes Clear, produces count/carry)
interface bcd_counter_if;
  import bcd_counter_pkg::*;

  logic   Clear;
  digit_t count;
  logic   carry;

  modport master (output Clear, input count, input carry);
  modport slave  (input Clear, output count, output carry);

endinterface

// File: rtl/bcd_counter.sv
// Single BCD digit counter cell, cascadable as a ripple counter.
//   CLK   : in  - sole clock, rising edge
//   count : out - registered BCD digit 0..9
//   Clear : in  - synchronous active-high clear, priority over counting
//   carry : out - registered one-period pulse on the 9->0 wrap; its rising
//                 edge coincides with count becoming 0 so it can clock the
//                 next higher digit directly
// Port order is fixed so cascades can instantiate by position.
module bcd_counter
  import bcd_counter_pkg::*;
(
  input  logic   CLK,
  output digit_t count,
  input  logic   Clear,
  output logic   carry
);

  digit_t count_q, count_d;
  logic   carry_q, carry_d;

  // Digits 10..15 can only appear through corruption; they fall back to zero
  // without signalling a carry so a downstream digit is not disturbed.
  function automatic digit_t next_digit(input digit_t cur);
    if (cur < BCD_MAX) return digit_t'(cur + 4'd1);
    return BCD_ZERO;
  endfunction

  always_comb begin
    count_d = next_digit(count_q);
    carry_d = (count_q == BCD_MAX);
  end

  // ---- register stage: count and carry updated together ----
  always_ff @(posedge CLK) begin
    if (Clear) begin
      count_q <= BCD_ZERO;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign count = count_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter: directed sequences, randomized Clear
// against a behavioural digit model, illegal-state recovery and a two-digit
// ripple cascade compared against an integer edge count.
module tb_bcd_counter;
  import bcd_counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  bcd_counter_if bus ();

  bcd_counter dut (
    .CLK   (clk),
    .count (bus.count),
    .Clear (bus.Clear),
    .carry (bus.carry)
  );

  // Two-digit ripple cascade: tens is clocked by the units carry. tb_tick
  // supplies the tens digit an edge while its Clear is held, since a ripple
  // stage only sees Clear on its own clock.
  logic   casc_clr;
  logic   tb_tick;
  digit_t u_cnt, t_cnt;
  logic   u_cy, t_cy;
  logic   tens_clk;
  assign tens_clk = u_cy | tb_tick;

  bcd_counter u_units (.CLK(clk),      .count(u_cnt), .Clear(casc_clr), .carry(u_cy));
  bcd_counter u_tens  (.CLK(tens_clk), .count(t_cnt), .Clear(casc_clr), .carry(t_cy));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model of one digit: a value in 0..9 that counts modulo ten.
  int m_cnt;
  int m_cy;

  task automatic model_step(input bit clr);
    if (clr) begin
      m_cnt = 0;
      m_cy  = 0;
    end else if (m_cnt > 9) begin
      m_cnt = 0;
      m_cy  = 0;
    end else begin
      m_cy  = (m_cnt == 9) ? 1 : 0;
      m_cnt = (m_cnt + 1) % 10;
    end
  endtask

  task automatic step(input bit clr);
    bus.Clear = clr;
    @(posedge clk);
    #1;
    model_step(clr);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, int'(bus.count), m_cnt);
    check({tag, ".carry"}, int'(bus.carry), m_cy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int prev_cy;
    int total;
    bus.Clear = 1'b1;
    casc_clr  = 1'b1;
    tb_tick   = 1'b0;
    m_cnt = 0;
    m_cy  = 0;

    // Reset from unknown state
    step(1);
    check("rst1.count", int'(bus.count), 0);
    check("rst1.carry", int'(bus.carry), 0);
    step(1);
    check("rst2.count", int'(bus.count), 0);
    check("rst2.carry", int'(bus.carry), 0);

    // Count up to 9, wrap, continue
    for (int i = 1; i <= 9; i++) begin
      step(0);
      check_model("up");
    end
    check("up9.count", int'(bus.count), 9);
    check("up9.carry", int'(bus.carry), 0);
    step(0);
    check("wrap.count", int'(bus.count), 0);
    check("wrap.carry", int'(bus.carry), 1);
    step(0);
    check("after_wrap.count", int'(bus.count), 1);
    check("after_wrap.carry", int'(bus.carry), 0);

    // Free run 30 edges: three single-cycle carry pulses aligned with zero
    step(1);
    pulses  = 0;
    prev_cy = 0;
    for (int i = 0; i < 30; i++) begin
      step(0);
      if (bus.carry === 1'b1) begin
        pulses++;
        check("pulse_aligned", int'(bus.count), 0);
        check("pulse_width", prev_cy, 0);
      end
      prev_cy = int'(bus.carry);
    end
    check("pulse_count", pulses, 3);

    // Clear mid-count
    step(1);
    for (int i = 0; i < 5; i++) step(0);
    check("mid5.count", int'(bus.count), 5);
    step(1);
    check("midclr.count", int'(bus.count), 0);
    check("midclr.carry", int'(bus.carry), 0);

    // Clear during the carry pulse
    for (int i = 0; i < 10; i++) step(0);
    check("pre_clr_pulse.carry", int'(bus.carry), 1);
    step(1);
    check("clr_pulse.count", int'(bus.count), 0);
    check("clr_pulse.carry", int'(bus.carry), 0);

    // Clear held for several edges, then resume
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_model("hold");
    end
    step(0);
    check("resume.count", int'(bus.count), 1);

    // Illegal digits 10..15 recover to zero without carry
    for (int v = 10; v <= 15; v++) begin
      @(negedge clk);
      bus.Clear = 1'b0;
      force dut.count_q = 4'(v);
      #1;
      check("forced.count", int'(bus.count), v);
      release dut.count_q;
      m_cnt = v;
      @(posedge clk);
      #1;
      model_step(0);
      check_model("illegal");
      check("illegal.zero", int'(bus.count), 0);
    end

    // Randomized Clear against the model
    step(1);
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 7) == 0);
      check_model("rand");
    end

    // Two-digit cascade
    @(negedge clk);
    tb_tick = 1'b1;
    #1;
    tb_tick = 1'b0;
    @(posedge clk);
    #1;
    check("casc_rst.units", int'(u_cnt), 0);
    check("casc_rst.tens", int'(t_cnt), 0);
    check("casc_rst.tcarry", int'(t_cy), 0);
    casc_clr = 1'b0;
    total = 0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk);
      #1;
      total++;
      check("casc.units", int'(u_cnt), total % 10);
      check("casc.tens", int'(t_cnt), (total / 10) % 10);
      check("casc.tcarry", int'(t_cy), (total % 100 == 0) ? 1 : 0);
      if (e == 10) begin
        check("casc10.tens", int'(t_cnt), 1);
        check("casc10.units", int'(u_cnt), 0);
      end
      if (e == 99) begin
        check("casc99.tens", int'(t_cnt), 9);
        check("casc99.units", int'(u_cnt), 9);
      end
      if (e == 100) begin
        check("casc100.tens", int'(t_cnt), 0);
        check("casc100.units", int'(u_cnt), 0);
        check("casc100.tcarry", int'(t_cy), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
